// File: rtl/svi_rr_scheduler_if.sv
// Request/grant bundle between the requester array and svi_rr_scheduler.
interface svi_rr_scheduler_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] i_req;
    logic             i_release;
    logic [N_REQ-1:0] o_gnt;
    logic             o_gnt_vld;
    logic [IDX_W-1:0] o_gnt_idx;
    logic             o_timeout;

    modport master (
        output i_req, i_release,
        input  o_gnt, o_gnt_vld, o_gnt_idx, o_timeout
    );

    modport slave (
        input  i_req, i_release,
        output o_gnt, o_gnt_vld, o_gnt_idx, o_timeout
    );
endinterface

// File: rtl/svi_rr_scheduler.sv
// Rotating-priority scheduler: one registered one-hot grant held until release.
// Define SVI_SCHED_TIMEOUT_EN to force-release grants after MAX_HOLD cycles.
module svi_rr_scheduler #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    svi_rr_scheduler_if.slave sched
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic             timeout_reg;

    // Masking with the live grant excludes the grantee on release and is a no-op in IDLE.
    logic [N_REQ-1:0] req_masked;
    assign req_masked = sched.i_req & ~gnt_reg;

    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                              : sum[IDX_W-1:0];
            assign cand_hit[gi] = req_masked[cand_idx[gi]];
        end
    endgenerate

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_vld = 1'b1;
                win_idx = cand_idx[k];
            end
        end
    end

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    logic hold_expired;

`ifdef SVI_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    logic [CNT_W-1:0] hold_cnt_reg;
    assign hold_expired = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
    wire unused_max_hold = |MAX_HOLD;
`endif

    logic implicit_rel;
    logic end_grant;
    logic forced_rel;
    assign implicit_rel = ~sched.i_req[idx_reg];
    assign end_grant    = sched.i_release | implicit_rel | hold_expired;
    assign forced_rel   = hold_expired & ~sched.i_release & ~implicit_rel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            idx_reg      <= '0;
            ptr_reg      <= '0;
            timeout_reg  <= 1'b0;
`ifdef SVI_SCHED_TIMEOUT_EN
            hold_cnt_reg <= '0;
`endif
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_vld) begin
                        state_reg    <= BUSY;
                        gnt_reg      <= N_REQ'(1) << win_idx;
                        idx_reg      <= win_idx;
                        ptr_reg      <= next_ptr(win_idx);
`ifdef SVI_SCHED_TIMEOUT_EN
                        hold_cnt_reg <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (end_grant) begin
                        timeout_reg <= forced_rel;
                        if (win_vld) begin
                            gnt_reg <= N_REQ'(1) << win_idx;
                            idx_reg <= win_idx;
                            ptr_reg <= next_ptr(win_idx);
                        end else if (!implicit_rel) begin
                            // Sole requester still asking: same grantee, fresh grant.
                            ptr_reg <= next_ptr(idx_reg);
                        end else begin
                            state_reg <= IDLE;
                            gnt_reg   <= '0;
                            idx_reg   <= '0;
                        end
`ifdef SVI_SCHED_TIMEOUT_EN
                        hold_cnt_reg <= '0;
`endif
                    end else begin
`ifdef SVI_SCHED_TIMEOUT_EN
                        hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sched.o_gnt     = gnt_reg;
    assign sched.o_gnt_vld = |gnt_reg;
    assign sched.o_gnt_idx = idx_reg;
    assign sched.o_timeout = timeout_reg;
endmodule

// File: tb/tb_svi_rr_scheduler.sv
// Bench for svi_rr_scheduler: 8-requester table plus hand sequences, and a 5-requester instance.
module tb_svi_rr_scheduler;
    localparam int MH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    svi_rr_scheduler_if #(.N_REQ(8), .IDX_W(3)) bus8 ();
    svi_rr_scheduler_if #(.N_REQ(5), .IDX_W(3)) bus5 ();

    svi_rr_scheduler #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MH)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sched   (bus8)
    );

    svi_rr_scheduler #(.N_REQ(5), .IDX_W(3), .MAX_HOLD(MH)) dut5 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sched   (bus5)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       to;
        string      name;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        logic       rel;
        logic [7:0] gnt;
        logic [2:0] idx;
        string      name;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step8(input logic [7:0] req, input logic rel, input logic [7:0] gnt,
                         input logic [2:0] idx, input logic to, input string name);
        exp_t e;
        bus8.i_req     = req;
        bus8.i_release = rel;
        e = '{gnt, idx, to, name};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("%s.gnt", e.name), 32'(bus8.o_gnt), 32'(e.gnt));
        chk($sformatf("%s.vld", e.name), 32'(bus8.o_gnt_vld), 32'(|e.gnt));
        chk($sformatf("%s.idx", e.name), 32'(bus8.o_gnt_idx), 32'(e.idx));
        chk($sformatf("%s.to", e.name), 32'(bus8.o_timeout), 32'(e.to));
        $display("txn n8 %-14s req=%h rel=%b gnt=%h idx=%0d to=%b",
                 e.name, req, rel, bus8.o_gnt, bus8.o_gnt_idx, bus8.o_timeout);
    endtask

    task automatic step5(input logic [4:0] req, input logic rel, input logic [4:0] gnt,
                         input logic [2:0] idx, input string name);
        exp_t e;
        bus5.i_req     = req;
        bus5.i_release = rel;
        e = '{8'(gnt), idx, 1'b0, name};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("%s.gnt", e.name), 32'(bus5.o_gnt), 32'(e.gnt));
        chk($sformatf("%s.idx", e.name), 32'(bus5.o_gnt_idx), 32'(e.idx));
        chk($sformatf("%s.range", e.name), 32'(bus5.o_gnt_idx < 3'd5), 32'd1);
        $display("txn n5 %-14s req=%h rel=%b gnt=%h idx=%0d",
                 e.name, req, rel, bus5.o_gnt, bus5.o_gnt_idx);
    endtask

    // Grant vectors must never carry more than one bit.
    always @(negedge clk) begin
        chk("mon8.onehot", 32'($onehot0(bus8.o_gnt)), 32'd1);
        chk("mon5.onehot", 32'($onehot0(bus5.o_gnt)), 32'd1);
    end

    initial begin
        logic [7:0] g;
        logic [2:0] ix;

        bus8.i_req = '0; bus8.i_release = 1'b0;
        bus5.i_req = '0; bus5.i_release = 1'b0;

        tbl[0] = '{8'hFF, 1'b0, 8'h01, 3'd0, "rot_first"};
        for (int k = 1; k <= 8; k++) begin
            ix = 3'(k % 8);
            g  = 8'(1) << ix;
            tbl[k] = '{8'hFF, 1'b1, g, ix, $sformatf("rot%0d", k)};
        end
        tbl[9]  = '{8'h80, 1'b1, 8'h80, 3'd7, "rel_to7"};
        tbl[10] = '{8'hC1, 1'b0, 8'h80, 3'd7, "hold7"};
        tbl[11] = '{8'h41, 1'b0, 8'h01, 3'd0, "wrap_to0"};
        tbl[12] = '{8'h10, 1'b1, 8'h10, 3'd4, "rel_to4"};
        tbl[13] = '{8'h10, 1'b1, 8'h10, 3'd4, "sole_regrant"};
        tbl[14] = '{8'h00, 1'b1, 8'h00, 3'd0, "drain"};
        tbl[15] = '{8'h00, 1'b0, 8'h00, 3'd0, "idle"};
        tbl[16] = '{8'h24, 1'b0, 8'h20, 3'd5, "ptr_at5"};
        tbl[17] = '{8'h2C, 1'b0, 8'h20, 3'd5, "hold5"};
        tbl[18] = '{8'h24, 1'b1, 8'h04, 3'd2, "rel_to2"};
        tbl[19] = '{8'h04, 1'b0, 8'h04, 3'd2, "hold2"};
        tbl[20] = '{8'h00, 1'b0, 8'h00, 3'd0, "implicit_idle"};
        tbl[21] = '{8'h00, 1'b1, 8'h00, 3'd0, "idle_rel"};

        // Reset state.
        @(posedge clk);
        #1;
        chk("rst.gnt", 32'(bus8.o_gnt), 32'd0);
        chk("rst.vld", 32'(bus8.o_gnt_vld), 32'd0);
        chk("rst.idx", 32'(bus8.o_gnt_idx), 32'd0);
        chk("rst.to", 32'(bus8.o_timeout), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 22; k++)
            step8(tbl[k].req, tbl[k].rel, tbl[k].gnt, tbl[k].idx, 1'b0, tbl[k].name);

        // Long hold: ptr is 3 here, so 8'h03 wraps to requester 0.
        step8(8'h03, 1'b0, 8'h01, 3'd0, 1'b0, "hold_g0");
`ifdef SVI_SCHED_TIMEOUT_EN
        for (int k = 1; k < MH; k++)
            step8(8'h03, 1'b0, 8'h01, 3'd0, 1'b0, "to_hold0");
        step8(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, "to_fire");
        for (int k = 1; k < MH; k++)
            step8(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, "to_hold1");
        step8(8'h03, 1'b1, 8'h01, 3'd0, 1'b0, "to_rel_norm");
`else
        for (int k = 0; k < 100; k++)
            step8(8'h03, 1'b0, 8'h01, 3'd0, 1'b0, "hold_long");
`endif
        step8(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "hold_drain");

        // Asynchronous reset in the middle of a grant.
        step8(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.gnt", 32'(bus8.o_gnt), 32'd0);
        chk("arst.vld", 32'(bus8.o_gnt_vld), 32'd0);
        chk("arst.idx", 32'(bus8.o_gnt_idx), 32'd0);
        chk("arst.to", 32'(bus8.o_timeout), 32'd0);
        $display("txn n8 %-14s gnt=%h idx=%0d", "async_rst", bus8.o_gnt, bus8.o_gnt_idx);
        bus8.i_req = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step8(8'h01, 1'b0, 8'h01, 3'd0, 1'b0, "post_rst");
        step8(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "post_drain");

        // Five requesters: pointer must wrap from 4 to 0.
        step5(5'h1F, 1'b0, 5'h01, 3'd0, "n5_first");
        for (int k = 1; k <= 5; k++) begin
            ix = 3'(k % 5);
            g  = 8'(1) << ix;
            step5(5'h1F, 1'b1, g[4:0], ix, $sformatf("n5_rot%0d", k));
        end
        step5(5'h00, 1'b0, 5'h00, 3'd0, "n5_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
